// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter:
// FSM state encoding and the line levels used on the serial output.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    // Line level while nothing is being sent (also the stop bit level).
    localparam logic UART_IDLE_LEVEL = 1'b1;
    // Line level of the start bit.
    localparam logic START_LEVEL     = 1'b0;
    // Width of the completed-frame counter.
    localparam int   TX_COUNT_W      = 16;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by the transmitter: pop strobe, empty flag and
// the registered read data that is valid the cycle after the pop.
interface fifo_uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 r_en;
    logic                 buff_empty;
    logic [DATA_BITS-1:0] buff_out;

    // Consumer side (the transmitter).
    modport master (
        output r_en,
        input  buff_empty,
        input  buff_out
    );

    // Producer side (the FIFO read port).
    modport slave (
        input  r_en,
        output buff_empty,
        output buff_out
    );
endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// bit period. Clear holds the count at zero so a new bit starts aligned.
module fifo_uart_tx_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam logic [15:0] TERM = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt_reg;
    logic [15:0] cnt_next;

    // Next count: zero on clear or terminal count, otherwise increment.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr || (cnt_reg == TERM)) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign tick = (cnt_reg == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO and sends each byte as an 8N1 UART frame.
// Sequence per byte: IDLE -> POP (r_en) -> LOAD (capture buff_out) ->
// START -> DATA (LSB first) -> STOP. tx is registered and computed from
// the next state, so the line level lines up with the state it belongs to.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic [TX_COUNT_W-1:0] tx_count
);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    state_t                state_reg, state_next;
    logic [DATA_BITS-1:0]  shift_reg, shift_next;
    logic [BIT_W-1:0]      bit_idx_reg, bit_idx_next;
    logic                  tx_reg, tx_next;
    logic                  r_en_reg, r_en_next;
    logic [TX_COUNT_W-1:0] tx_count_reg, tx_count_next;
    logic                  baud_clr;
    logic                  baud_tick;

    fifo_uart_tx_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .tick (baud_tick)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_idx_next  = bit_idx_reg;
        r_en_next     = 1'b0;
        tx_count_next = tx_count_reg;
        baud_clr      = 1'b1;
        tx_next       = UART_IDLE_LEVEL;

        case (state_reg)
            ST_IDLE: begin
                // Pop strobe is registered, so it is high during POP.
                if (tx_en && !fifo.buff_empty) begin
                    state_next = ST_POP;
                    r_en_next  = 1'b1;
                end
            end
            ST_POP: begin
                // Sole reader of the FIFO: the byte is guaranteed to arrive.
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                shift_next = fifo.buff_out;
                state_next = ST_START;
            end
            ST_START: begin
                baud_clr = 1'b0;
                if (baud_tick) begin
                    state_next   = ST_DATA;
                    bit_idx_next = '0;
                end
            end
            ST_DATA: begin
                baud_clr = 1'b0;
                if (baud_tick) begin
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                        shift_next   = shift_reg >> 1;
                    end
                end
            end
            ST_STOP: begin
                baud_clr = 1'b0;
                if (baud_tick) begin
                    tx_count_next = tx_count_reg + 1'b1;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        case (state_next)
            ST_START: tx_next = START_LEVEL;
            ST_DATA:  tx_next = shift_next[0];
            default:  tx_next = UART_IDLE_LEVEL;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            bit_idx_reg  <= '0;
            tx_reg       <= UART_IDLE_LEVEL;
            r_en_reg     <= 1'b0;
            tx_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_idx_reg  <= bit_idx_next;
            tx_reg       <= tx_next;
            r_en_reg     <= r_en_next;
            tx_count_reg <= tx_count_next;
        end
    end

    assign fifo.r_en = r_en_reg;
    assign tx        = tx_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign tx_count  = tx_count_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed/random bench for fifo_uart_tx: a queue-based FIFO model feeds
// bytes, and each frame is checked cycle by cycle against the 8N1 waveform
// computed from the byte value.
module tb_fifo_uart_tx;
    localparam int CPB    = 4;
    localparam int PERIOD = 3 + 10 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_en;
    logic        tx;
    logic        busy;
    logic [15:0] tx_count;

    fifo_uart_tx_if #(.DATA_BITS(8)) fif ();

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_en    (tx_en),
        .fifo     (fif),
        .tx       (tx),
        .busy     (busy),
        .tx_count (tx_count)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    int          pushes = 0;
    int          underflow = 0;
    logic [15:0] model_count = 16'd0;
    logic [7:0]  q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO read-port model: data registered one cycle after r_en.
    always @(posedge clk) begin
        if (fif.r_en === 1'b1) begin
            pops <= pops + 1;
            if (q.size() > 0) fif.buff_out <= q.pop_front();
            else underflow <= underflow + 1;
        end
        fif.buff_empty <= (q.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        pushes++;
    endtask

    // Step negedges until r_en is seen or the budget runs out.
    task automatic wait_pop(output bit seen);
        int n = 0;
        while (fif.r_en !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("pop_seen", fif.r_en, 1'b1);
        seen = (fif.r_en === 1'b1);
    endtask

    // Check one whole frame from its POP cycle to the IDLE cycle after it.
    task automatic run_frame(input logic [7:0] b, input bit drop_en, output int pop_cyc);
        bit   seen;
        logic exp_bit;
        pop_cyc = -1;
        wait_pop(seen);
        if (!seen) return;
        pop_cyc = cyc;
        @(negedge clk);
        chk("pop_width", fif.r_en, 1'b0);
        chk("load_tx", tx, 1'b1);
        chk("load_busy", busy, 1'b1);
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < CPB; k++) begin
                @(negedge clk);
                if (j == 0) exp_bit = 1'b0;
                else if (j == 9) exp_bit = 1'b1;
                else exp_bit = (b >> (j - 1)) & 8'd1;
                chk("frame_tx", tx, exp_bit);
                if (drop_en && j == 3 && k == 0) tx_en = 1'b0;
            end
        end
        @(negedge clk);
        model_count = model_count + 16'd1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_tx", tx, 1'b1);
        chk("tx_count", tx_count, model_count);
        $display("frame byte=%02h pop_cycle=%0d tx_count=%0d", b, pop_cyc, tx_count);
    endtask

    initial begin
        int         viol;
        int         pc[5];
        int         dummy;
        bit         seen;
        logic [7:0] rb[5];

        // Reset with an empty FIFO and transmit enabled.
        rst = 1'b1;
        tx_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_r_en", fif.r_en, 1'b0);
        chk("rst_count", tx_count, 16'd0);
        rst = 1'b0;

        // 100 cycles enabled but empty: nothing may happen.
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (fif.r_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        chk("empty_idle_viol", viol, 0);
        chk("empty_pops", pops, 0);
        chk("empty_count", tx_count, 16'd0);
        $display("empty idle: 100 cycles, violations=%0d", viol);

        // Single byte 0xA5.
        push(8'hA5);
        run_frame(8'hA5, 1'b0, dummy);
        chk("a5_pops", pops, 1);

        // Three back-to-back bytes.
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        run_frame(8'h00, 1'b0, pc[0]);
        run_frame(8'hFF, 1'b0, pc[1]);
        run_frame(8'h3C, 1'b0, pc[2]);
        chk("b2b_gap01", pc[1] - pc[0], PERIOD);
        chk("b2b_gap12", pc[2] - pc[1], PERIOD);
        chk("b2b_empty", fif.buff_empty, 1'b1);
        chk("b2b_count", tx_count, 16'd4);

        // tx_en dropped mid-frame with a second byte queued.
        rb[0] = 8'($urandom);
        rb[1] = 8'($urandom);
        push(rb[0]);
        push(rb[1]);
        run_frame(rb[0], 1'b1, dummy);
        viol = 0;
        repeat (40) begin
            @(negedge clk);
            if (fif.r_en !== 1'b0 || busy !== 1'b0) viol++;
        end
        chk("hold_viol", viol, 0);
        chk("hold_empty", fif.buff_empty, 1'b0);
        $display("tx_en low: 40 cycles held, violations=%0d", viol);
        tx_en = 1'b1;
        run_frame(rb[1], 1'b0, dummy);

        // Random burst of back-to-back frames.
        for (int i = 0; i < 5; i++) begin
            rb[i] = 8'($urandom);
            push(rb[i]);
        end
        for (int i = 0; i < 5; i++) run_frame(rb[i], 1'b0, pc[i]);
        for (int i = 1; i < 5; i++) chk("rand_gap", pc[i] - pc[i-1], PERIOD);

        // Reset in the middle of data bit 3 of 0x55.
        push(8'h55);
        wait_pop(seen);
        if (seen) begin
            repeat (1 + CPB + 3 * CPB + 2) @(negedge clk);
            chk("mid_tx_bit3", tx, 1'b0);
            rst = 1'b1;
            @(negedge clk);
            model_count = 16'd0;
            chk("midrst_tx", tx, 1'b1);
            chk("midrst_count", tx_count, model_count);
            chk("midrst_r_en", fif.r_en, 1'b0);
            @(negedge clk);
            rst = 1'b0;
            viol = 0;
            repeat (30) begin
                @(negedge clk);
                if (fif.r_en !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) viol++;
            end
            chk("midrst_idle_viol", viol, 0);
            chk("midrst_count2", tx_count, 16'd0);
            $display("reset mid-frame: tx=%0b tx_count=%0d", tx, tx_count);
        end

        // Counter wrap from 0xFFFF.
        force dut.tx_count_reg = 16'hFFFF;
        @(negedge clk);
        release dut.tx_count_reg;
        @(negedge clk);
        model_count = 16'hFFFF;
        chk("preload_count", tx_count, model_count);
        rb[0] = 8'($urandom);
        push(rb[0]);
        run_frame(rb[0], 1'b0, dummy);
        chk("wrap_count", tx_count, 16'h0000);

        // Bookkeeping: every push popped once, never popped while empty.
        chk("underflow", underflow, 0);
        chk("pops_total", pops, pushes);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
